// File: rtl/disp_pkg.sv
// Shared seven-segment constants: segment bit positions and the active-low hex glyph table.
package disp_pkg;

  localparam int unsigned SEG_A   = 0;
  localparam int unsigned SEG_B   = 1;
  localparam int unsigned SEG_C   = 2;
  localparam int unsigned SEG_D   = 3;
  localparam int unsigned SEG_E   = 4;
  localparam int unsigned SEG_F   = 5;
  localparam int unsigned SEG_G   = 6;
  localparam int unsigned SEG_DP  = 7;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned NIB_W   = 4;

  // Bit order g,f,e,d,c,b,a; 0 lights a segment. Entry 15 (F) is listed first.
  localparam logic [15:0][GLYPH_W-1:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [NIB_W-1:0]   nibble,
  output logic [GLYPH_W-1:0] glyph_c
);

  assign glyph_c = HEX_GLYPHS[nibble];

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed seven-segment driver: snapshots the display word on load and scans
// one digit per slot with blanking, blinking and leading-zero suppression.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NIB_W*DIGITS-1:0] hexs,
  input  logic [DIGITS-1:0]       points,
  input  logic [DIGITS-1:0]       blink,
  input  logic [DIGITS-1:0]       blank,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [DIGITS-1:0]       an,
  output logic [7:0]              seg,
  output logic                    frame
);

  localparam int unsigned HEX_W = NIB_W * DIGITS;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [HEX_W-1:0]   hexs_snap_q,   hexs_snap_d;
  logic [DIGITS-1:0]  points_snap_q, points_snap_d;
  logic [DIGITS-1:0]  blink_snap_q,  blink_snap_d;
  logic [DIGITS-1:0]  blank_snap_q,  blank_snap_d;
  logic [PRE_W-1:0]   presc_q,       presc_d;
  logic [IDX_W-1:0]   idx_q,         idx_d;
  logic [BLK_W-1:0]   blink_cnt_q,   blink_cnt_d;
  logic               phase_q,       phase_d;
  logic [DIGITS-1:0]  an_q,          an_d;
  logic [7:0]         seg_q,         seg_d;
  logic               frame_q,       frame_d;

  logic               slot_end_c;
  logic               frame_end_c;
  logic [DIGITS:0]    zero_from_c;
  logic [NIB_W-1:0]   nib_sel_c;
  logic               dp_sel_c;
  logic               blank_sel_c;
  logic               blink_sel_c;
  logic               lz_sel_c;
  logic [DIGITS-1:0]  an_sel_c;
  logic [GLYPH_W-1:0] glyph_c;

  // Snapshot capture; the captured value is forwarded so a load shows on the very next cycle.
  always_comb begin
    hexs_snap_d   = hexs_snap_q;
    points_snap_d = points_snap_q;
    blink_snap_d  = blink_snap_q;
    blank_snap_d  = blank_snap_q;
    if (load) begin
      hexs_snap_d   = hexs;
      points_snap_d = points;
      blink_snap_d  = blink;
      blank_snap_d  = blank;
    end
  end

  // Prescaler, digit index and frame-synchronous blink phase.
  always_comb begin
    presc_d     = presc_q + PRE_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    slot_end_c  = (presc_q == PRE_MAX);
    frame_end_c = slot_end_c && (idx_q == IDX_MAX);
    if (slot_end_c) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_end_c) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Zero-prefix chain from the MSB digit down, then the per-slot digit mux.
  always_comb begin
    zero_from_c         = '0;
    zero_from_c[DIGITS] = 1'b1;
    for (int i = DIGITS; i > 0; i--) begin
      zero_from_c[i-1] = zero_from_c[i] && (hexs_snap_d[NIB_W*(i-1) +: NIB_W] == 4'h0);
    end
    nib_sel_c   = '0;
    dp_sel_c    = 1'b0;
    blank_sel_c = 1'b0;
    blink_sel_c = 1'b0;
    lz_sel_c    = 1'b0;
    an_sel_c    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel_c   = hexs_snap_d[NIB_W*i +: NIB_W];
        dp_sel_c    = points_snap_d[i];
        blank_sel_c = blank_snap_d[i];
        blink_sel_c = blink_snap_d[i];
        lz_sel_c    = zero_from_c[i] && (i != 0);
        an_sel_c[i] = 1'b0;
      end
    end
  end

  seg_decoder u_seg_decoder (
    .nibble  (nib_sel_c),
    .glyph_c (glyph_c)
  );

  // Output stage: an off digit releases its anode; a suppressed digit keeps the anode and dp.
  always_comb begin
    an_d    = '1;
    seg_d   = 8'hFF;
    frame_d = frame_end_c;
    if (!(blank_sel_c || (blink_sel_c && phase_q))) begin
      an_d                 = an_sel_c;
      seg_d[SEG_DP]        = ~dp_sel_c;
      seg_d[SEG_DP-1:0]    = (lz_en && lz_sel_c) ? 7'h7F : glyph_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hexs_snap_q   <= '0;
      points_snap_q <= '0;
      blink_snap_q  <= '0;
      blank_snap_q  <= '0;
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      an_q          <= '1;
      seg_q         <= 8'hFF;
      frame_q       <= 1'b0;
    end else begin
      hexs_snap_q   <= hexs_snap_d;
      points_snap_q <= points_snap_d;
      blink_snap_q  <= blink_snap_d;
      blank_snap_q  <= blank_snap_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_q       <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule
